// File: rtl/fft_psd_unit.sv
// Power-spectrum sink behind fft_core: accumulates |X|^2 per bin over
// 2^AVG_LOG2 frames, then drains the averaged spectrum bin by bin.
module fft_psd_unit #(
    parameter int unsigned FFT_SIZE   = 1024,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    fft_in_valid_i,
    input  logic [2*DATA_WIDTH-1:0] fft_in_data_i,
    output logic                    fft_in_ready_o,
    output logic                    psd_valid_o,
    output logic [2*DATA_WIDTH-1:0] psd_data_o,
    output logic                    psd_last_o,
    input  logic                    psd_ready_i,
    output logic                    frame_done_o,
    output logic                    busy_o
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned AW = PW + AVG_LOG2;
    localparam int unsigned BW = $clog2(FFT_SIZE);
    localparam int unsigned FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [BW-1:0] BIN_LAST = BW'(FFT_SIZE - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        ACCUM,
        DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [BW-1:0] bin_cnt_q;
    logic [BW-1:0] rd_idx_q;
    logic [FW-1:0] frame_cnt_q;
    logic          frame_done_q;

    logic [AW-1:0] acc_q [FFT_SIZE];

    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
    logic signed [PW-1:0]         re_sq;
    logic signed [PW-1:0]         im_sq;
    logic [PW-1:0]                pwr;

    logic in_accum;
    logic in_drain;
    logic accept;
    logic out_hs;
    logic last_bin;
    logic frame_end;

    assign re = fft_in_data_i[PW-1 -: DATA_WIDTH];
    assign im = fft_in_data_i[DATA_WIDTH-1:0];

    // Squares are non-negative and their sum tops out at 2^(PW-1).
    assign re_sq = PW'(re) * PW'(re);
    assign im_sq = PW'(im) * PW'(im);
    assign pwr   = $unsigned(re_sq) + $unsigned(im_sq);

    assign in_accum  = (state_q == ACCUM);
    assign in_drain  = (state_q == DRAIN);
    assign accept    = in_accum && fft_in_valid_i && !clear_i;
    assign out_hs    = in_drain && psd_ready_i;
    assign last_bin  = in_drain && (rd_idx_q == BIN_LAST);
    assign frame_end = (bin_cnt_q == BIN_LAST)
                    && (frame_cnt_q == FRM_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fft_in_ready_o = 1'b0;
        psd_valid_o    = 1'b0;
        busy_o         = 1'b0;
        unique case (state_q)
            ACCUM: begin
                fft_in_ready_o = 1'b1;
                if (accept && frame_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                psd_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (out_hs && last_bin) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (clear_i) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            rd_idx_q     <= '0;
            frame_done_q <= 1'b0;
        end else if (clear_i) begin
            bin_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            rd_idx_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= out_hs && last_bin;
            if (accept) begin
                bin_cnt_q <= bin_cnt_q + BW'(1);
                if (bin_cnt_q == BIN_LAST) begin
                    frame_cnt_q <= frame_end ? '0
                                 : frame_cnt_q + FW'(1);
                end
            end
            if (out_hs) begin
                rd_idx_q <= last_bin ? '0 : rd_idx_q + BW'(1);
            end
        end
    end

    // Frame 0 overwrites, so the array never needs a reset or clear.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            acc_q[bin_cnt_q] <= (frame_cnt_q == '0) ? AW'(pwr)
                              : acc_q[bin_cnt_q] + AW'(pwr);
        end
    end

    assign psd_data_o   = in_drain ? PW'(acc_q[rd_idx_q] >> AVG_LOG2)
                        : '0;
    assign psd_last_o   = last_bin;
    assign frame_done_o = frame_done_q;

endmodule

// File: doc/fft_psd_unit.md
# fft_psd_unit

Streaming power-spectrum sink that sits directly behind `fft_core` and consumes its complex output handshake (`fft_out_valid_o` / `fft_out_data_o` / `fft_out_ready_i`). For each bin it computes |X|² = re² + im² and averages it over 2^AVG_LOG2 consecutive FFT frames in an internal accumulator file. It then drains the averaged spectrum, one bin per handshake, to a downstream valid/ready stream with a last-bin marker. This is the readout end of the FFT datapath.

## Interface
- FFT_SIZE, 1024, bins per frame; power of two, ≥ 2.
- DATA_WIDTH, 16, width of each of re and im (signed).
- AVG_LOG2, 2, log2 of frames averaged; 0 means no averaging.
- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous abort; returns the block to ACCUM with counters at zero.
- fft_in_valid_i  input  1  input bin valid.
- fft_in_data_i  input  2*DATA_WIDTH  {re, im}; re in the upper half. Both halves are signed.
- fft_in_ready_o  output  1  block accepts an input bin.
- psd_valid_o  output  1  output bin valid.
- psd_data_o  output  2*DATA_WIDTH  averaged power, unsigned.
- psd_last_o  output  1  high with the bin at index FFT_SIZE-1.
- psd_ready_i  input  1  downstream accepts the output bin.
- frame_done_o  output  1  one-cycle pulse after the last output handshake.
- busy_o  output  1  high while in DRAIN.

## Operation
- **States.** Two states: ACCUM and DRAIN. Reset and clear_i enter ACCUM with bin_cnt = 0, frame_cnt = 0 and rd_idx = 0.
- **Output decode.**
  - ACCUM: fft_in_ready_o = 1, psd_valid_o = 0.
  - DRAIN: fft_in_ready_o = 0, psd_valid_o = 1, busy_o = 1.
- **Input accept.** An input bin is accepted when fft_in_valid_i && fft_in_ready_o. On each accept:
  - p = re*re + im*im, evaluated at 2*DATA_WIDTH bits unsigned. The maximum is 2^(2*DATA_WIDTH-1), at re = im = -2^(DATA_WIDTH-1), so p never wraps.
  - acc[bin_cnt] <= (frame_cnt == 0) ? p : acc[bin_cnt] + p. Because frame 0 overwrites, stale contents never need clearing.
  - Accumulator width is 2*DATA_WIDTH + AVG_LOG2, which is sufficient for 2^AVG_LOG2 maximum values.
  - bin_cnt increments and wraps from FFT_SIZE-1 to 0. On that wrap, frame_cnt increments.
  - On the accept where bin_cnt == FFT_SIZE-1 and frame_cnt == 2^AVG_LOG2-1, the next state is DRAIN and frame_cnt returns to 0.
- **Drain.**
  - psd_data_o = acc[rd_idx] >> AVG_LOG2, truncated to 2*DATA_WIDTH bits (truncation is exact by construction).
  - psd_last_o = (rd_idx == FFT_SIZE-1) while in DRAIN, else 0.
  - rd_idx increments on psd_valid_o && psd_ready_i.
  - On the handshake with psd_last_o: next state is ACCUM, rd_idx = 0, and frame_done_o pulses for 1 cycle (registered).
- **clear_i** has priority over all state updates. Accumulator contents are left untouched.

## Timing
- **Reset values:**
  - fft_in_ready_o = 1 (ACCUM).
  - psd_valid_o = 0, psd_data_o = 0, psd_last_o = 0.
  - frame_done_o = 0, busy_o = 0.
- **Input throughput:** one bin per cycle in ACCUM; no input bubbles are required.
- **Last-input to output latency:** last accept at edge T; psd_valid_o is high from T+1.
- **Output throughput:** DRAIN lasts at least FFT_SIZE cycles. The first input accept of the next frame can occur the cycle after the final output handshake.
- **Backpressure:** while psd_valid_o && !psd_ready_i, psd_data_o and psd_last_o hold stable. psd_valid_o never drops inside DRAIN.
- **No concurrent in/out:** input and output never transfer in the same cycle; upstream stalls for the whole DRAIN.
- **Reset mid-operation:** asynchronous. Outputs take their reset values immediately, and the partially accumulated frame is discarded.
- **clear_i in DRAIN:** the cycle after, psd_valid_o = 0 and fft_in_ready_o = 1.
- **clear_i together with an accept:** the input beat is dropped.
- **AVG_LOG2 = 0:** each frame drains immediately and psd_data_o = p.

## Test plan
- **Single-bin power.** FFT_SIZE=8, AVG_LOG2=0, psd_ready_i=1; bin 2 = {re=3, im=4}, all other bins 0. Expect output sequence 0,0,25,0,0,0,0,0; psd_last_o only on the 8th beat; frame_done_o one pulse one cycle later.
- **Averaging.** FFT_SIZE=8, AVG_LOG2=2; bin 0 re = 2, 4, 6, 8 across four frames, im=0. Expect bin 0 = (4+16+36+64)>>2 = 30; psd_valid_o rises exactly one cycle after the 32nd accept.
- **Extreme magnitude.** All bins re = im = -32768, DATA_WIDTH=16, AVG_LOG2=2. Expect every output = 0x8000_0000, with no wrap.
- **Backpressure.**
  - psd_ready_i low for 5 cycles at rd_idx=3, then random toggling.
  - Expect psd_data_o stable while stalled, all 8 bins delivered once and in order.
  - fft_in_ready_o low throughout DRAIN even with fft_in_valid_i held high.
- **Reset mid-drain.** Assert rst_ni after 3 output handshakes. Expect all outputs at reset values; the next 2^AVG_LOG2 frames produce the correct averages with no contribution from stale accumulator data.
- **clear_i mid-accumulation.** Pulse clear_i during frame 1 at bin 5. Expect counters reset; a fresh 4-frame sequence yields averages of only those 4 frames.
